adder_share_arbiter: RTL
========================

Name: adder_share_arbiter

Overview:
- Shares one 8-bit Sklansky prefix adder instance among NUM_REQ requesters, e.g. the neuron's SAD difference/accumulate lanes.
- Round-robin arbitration; operands captured into registers, sum registered, result returned on a single response channel tagged with the requester ID.
- Sits between the per-lane neuron logic and the shared adder datapath; the only path by which lanes reach the adder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of response ID; must equal clog2(NUM_REQ), minimum 1

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high; state cleared on assertion, release synchronous to clk
- req_valid  input  NUM_REQ  per-requester request valid
- req_a  input  8*NUM_REQ  operand A, requester i at bits [8i+7:8i]
- req_b  input  8*NUM_REQ  operand B, same packing
- req_ready  output  NUM_REQ  one-hot grant/accept strobe
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_sum  output  8  registered sum
- rsp_id  output  ID_W  index of requester that issued this result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0, operand registers=0.
- Handshake rule: request transfers on the cycle req_valid[i]&req_ready[i]=1. Requester holds valid and operands stable until then. Response transfers when rsp_valid&rsp_ready=1.
- FSM:
  - IDLE: if any req_valid, pick winner w = first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...). req_ready[w]=1 combinationally this cycle, all other req_ready bits 0. On the edge, latch a_q=req_a[w], b_q=req_b[w], id_q=w, go to ADD. If no valid, stay in IDLE with req_ready=0.
  - ADD: adder is fed a_q/b_q. On the edge, rsp_sum <= adder sum, rsp_id <= id_q, rsp_valid <= 1, go to RESP.
  - RESP: hold rsp_valid/rsp_sum/rsp_id stable. When rsp_ready=1: on the edge rsp_valid <= 0, rr_ptr <= (id_q+1) mod NUM_REQ, go to IDLE. rsp_ready in IDLE/ADD is ignored.
- Latency: grant at cycle T, rsp_valid at T+2. Minimum issue interval 3 cycles with rsp_ready tied high.
- Arithmetic: sum = (a+b) mod 256; no carry-in.
- Fairness: after serving w, w has lowest priority. Under continuous requests each requester is served at least once every NUM_REQ grants.
- Simultaneous events:
  - A new request arriving during ADD/RESP waits; no grant outside IDLE.
  - Deasserting req_valid before it is granted is legal; that request is never served.
- Reset mid-operation: async assertion immediately drops rsp_valid and req_ready, returns to IDLE, and discards any in-flight result.
- req_ready has no combinational path from rsp_ready.

Optional Feature:
- Macro ADDER_ARB_SAT_EN.
- Defined:
  - Carry is derived as c = (a7&b7) | ((a7^b7)&~s7) from the adder's MSB.
  - If c=1, rsp_sum <= 8'hFF.
  - Extra output rsp_ovf (1 bit), registered alongside rsp_sum, reset 0, equal to c.
- Undefined: wrap-around sum, no rsp_ovf port.

Test Plan:
- Reset then req_valid=4'b0001, a0=8'h12, b0=8'h34, rsp_ready=1 -> req_ready=4'b0001 at T, rsp_valid at T+2 with rsp_sum=8'h46, rsp_id=0, back to IDLE at T+3.
- req_valid=4'b1111 held for 4 transactions, rsp_ready=1 -> grant order 0,1,2,3, then 0 again. Each response's rsp_id matches the issuing requester.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_sum, rsp_id stable, busy=1, no req_ready pulses. Raise rsp_ready -> exactly one transfer.
- Wrap: a=8'hF0, b=8'h20 -> rsp_sum=8'h10 with macro undefined. With ADDER_ARB_SAT_EN -> rsp_sum=8'hFF, rsp_ovf=1. With a=8'h7F, b=8'h01 -> 8'h80, rsp_ovf=0.
- Assert rst during RESP (rsp_valid=1) -> rsp_valid=0 before the next edge. After release, the first grant goes to the lowest-index valid requester (rr_ptr=0).
- Requester 2 drops req_valid while requester 1 is being served -> next grant skips 2. Only 4'b1001 requesters get served, order 3, then 0.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin arbiter that time-shares one 8-bit
// Sklansky prefix adder among NUM_REQ requesters. Each request passes
// through IDLE (grant + operand capture), ADD (registered sum) and RESP
// (result held until the consumer accepts it).
// Optional build macro ADDER_ARB_SAT_EN: saturate the sum to 8'hFF on
// carry-out and expose the carry as rsp_ovf.

module sklansky_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum
);

  // Parallel-prefix carry network, no carry-in. Level k merges every node
  // whose bit k is set with the last node of the lower half of its
  // 2^(k+1) block, giving log2(8)=3 levels with fan-out doubling per level.
  function automatic logic [7:0] prefix_add(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] g;
    logic [7:0] gg;
    logic [7:0] pp;
    logic [7:0] gn;
    logic [7:0] pn;
    logic [7:0] s;
    int         j;
    p  = x ^ y;
    g  = x & y;
    gg = g;
    pp = p;
    for (int k = 0; k < 3; k++) begin
      gn = gg;
      pn = pp;
      for (int i = 0; i < 8; i++) begin
        if (((i >> k) & 1) == 1) begin
          j     = ((i >> k) << k) - 1;
          gn[i] = gg[i] | (pp[i] & gg[j]);
          pn[i] = pp[i] & pp[j];
        end
      end
      gg = gn;
      pp = pn;
    end
    s[0] = p[0];
    for (int i = 1; i < 8; i++) begin
      s[i] = p[i] ^ gg[i-1];
    end
    return s;
  endfunction

  // Pure combinational sum of the two operands
  always_comb begin
    sum = prefix_add(a, b);
  end

endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_sum,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
`ifdef ADDER_ARB_SAT_EN
  ,
  output logic                 rsp_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id_q;
  logic [7:0]      a_q;
  logic [7:0]      b_q;
  logic [7:0]      sum_w;
  logic [ID_W-1:0] winner;
  logic [ID_W:0]   cand;
  logic            any_valid;

  assign any_valid = |req_valid;
  assign busy      = (state != IDLE);

  // The one shared adder, always fed from the captured operand registers
  sklansky_adder8 u_adder (
    .a   (a_q),
    .b   (b_q),
    .sum (sum_w)
  );

  // Round-robin search from rr_ptr upward with wrap; scanning offsets from
  // the far end down lets the closest valid requester overwrite the others.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (req_valid[cand[ID_W-1:0]]) begin
        winner = cand[ID_W-1:0];
      end
    end
  end

  // One-hot grant only while idle; reset gates it off immediately and
  // rsp_ready never reaches this path.
  always_comb begin
    req_ready = '0;
    if ((state == IDLE) && !rst && any_valid) begin
      req_ready[winner] = 1'b1;
    end
  end

`ifdef ADDER_ARB_SAT_EN
  logic sat_carry;
  assign sat_carry = (a_q[7] & b_q[7]) | ((a_q[7] ^ b_q[7]) & ~sum_w[7]);
`endif

  // Arbiter FSM: capture winner's operands, register the sum, hold the
  // response until accepted, then rotate priority past the served requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
`ifdef ADDER_ARB_SAT_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            a_q   <= req_a[{winner, 3'b000} +: 8];
            b_q   <= req_b[{winner, 3'b000} +: 8];
            id_q  <= winner;
            state <= ADD;
          end
        end
        ADD: begin
`ifdef ADDER_ARB_SAT_EN
          rsp_sum <= sat_carry ? 8'hFF : sum_w;
          rsp_ovf <= sat_carry;
`else
          rsp_sum <= sum_w;
`endif
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
